// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-driven bus master: FSM state codes,
// command bytes and the default write acknowledgement byte.
package uart_bus_master_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t ADDR  = 3'd1;
   localparam state_t DATA  = 3'd2;
   localparam state_t WRITE = 3'd3;
   localparam state_t READ  = 3'd4;
   localparam state_t TX    = 3'd5;

   localparam logic [7:0] CMD_WRITE        = 8'h57;
   localparam logic [7:0] CMD_READ         = 8'h52;
   localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h4B;

endpackage

// File: rtl/uart_bus_master_bus_tx_shifter.sv
// Response shifter: holds up to four bytes and presents them MSB first
// to the UART transmitter with a valid/ready handshake.
module bus_tx_shifter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [2:0]  load_count,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] shift_reg;
   logic [2:0]  count;

   assign tx_data = shift_reg[31:24];
   // Last byte of the response is being accepted this cycle.
   assign done    = tx_valid && tx_ready && (count == 3'd1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         count     <= '0;
         tx_valid  <= 1'b0;
      end else if (load) begin
         shift_reg <= load_data;
         count     <= load_count;
         tx_valid  <= (load_count != 3'd0);
      end else if (tx_valid && tx_ready) begin
         shift_reg <= {shift_reg[23:0], 8'h00};
         count     <= count - 3'd1;
         if (count == 3'd1)
            tx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side bus initiator: parses write/read frames from a UART byte
// stream, issues single-word bus accesses and returns ack/read data bytes.
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter int         TIMEOUT  = 100000,
   parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        busy,
   output logic        overrun
);

   localparam int            TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;

   state_t           state;
   logic             is_read;
   logic [1:0]       byte_cnt;
   logic [31:0]      addr_reg;
   logic [31:0]      wdata_reg;
   logic [TMO_W-1:0] tmo_cnt;

   logic             load;
   logic [31:0]      load_data;
   logic [2:0]       load_count;
   logic             tx_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         is_read   <= 1'b0;
         byte_cnt  <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         tmo_cnt   <= '0;
         overrun   <= 1'b0;
      end else begin
         // Bytes arriving while an access or response is in flight are lost.
         if (rx_valid && (state == WRITE || state == READ || state == TX))
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                  is_read  <= (rx_data == CMD_READ);
                  byte_cnt <= '0;
                  tmo_cnt  <= '0;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (rx_valid) begin
                  addr_reg <= {addr_reg[23:0], rx_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  tmo_cnt  <= '0;
                  if (byte_cnt == 2'd3)
                     state <= is_read ? READ : DATA;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            DATA: begin
               if (rx_valid) begin
                  wdata_reg <= {wdata_reg[23:0], rx_data};
                  byte_cnt  <= byte_cnt + 2'd1;
                  tmo_cnt   <= '0;
                  if (byte_cnt == 2'd3)
                     state <= WRITE;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            WRITE:   state <= TX;
            READ:    state <= TX;
            TX:      if (tx_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through it can leave a value unassigned and infer a latch.
   always_comb begin
      wr    = 1'b0;
      rd    = 1'b0;
      addr  = '0;
      wdata = '0;
      if (state == WRITE) begin
         wr    = 1'b1;
         addr  = addr_reg & WORD_MASK;
         wdata = wdata_reg;
      end else if (state == READ) begin
         rd   = 1'b1;
         addr = addr_reg & WORD_MASK;
      end
   end

   assign busy       = (state != IDLE);
   assign load       = (state == WRITE) || (state == READ);
   assign load_data  = (state == READ) ? rdata : {ACK_BYTE, 24'h000000};
   assign load_count = (state == READ) ? 3'd4 : 3'd1;

   bus_tx_shifter u_tx_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_data  (load_data),
      .load_count (load_count),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .done       (tx_done)
   );

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write/read frames, stalled responses,
// inter-byte timeout, address alignment, overrun and mid-frame reset.
module tb_uart_bus_master;

   localparam int TMO = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        overrun;
   logic [31:0] rdata_val;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;
   int both_cnt = 0;
   logic [31:0] rd_addr = '0;

   always #5 clk = ~clk;

   uart_bus_master #(.TIMEOUT(TMO), .ACK_BYTE(8'h4B)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .overrun  (overrun)
   );

   // Bus slave model: combinational read data while rd is high.
   assign rdata = rd ? rdata_val : 32'h0;

   always @(negedge clk) begin
      if (wr) wr_cnt++;
      if (rd) begin
         rd_cnt++;
         rd_addr = addr;
      end
      if (wr && rd) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap = 0);
      repeat (gap) step();
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic recv_byte(input int stall, output logic [7:0] b);
      int   waited = 0;
      logic stable = 1'b1;
      while (!tx_valid && waited < 50) begin
         step();
         waited++;
      end
      if (!tx_valid) begin
         check("tx_wait", 32'(tx_valid), 32'd1);
         b = '0;
         return;
      end
      b = tx_data;
      for (int i = 0; i < stall; i++) begin
         step();
         if (tx_data !== b || tx_valid !== 1'b1) stable = 1'b0;
      end
      if (stall > 0) check("tx_stable", 32'(stable), 32'd1);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
   endtask

   task automatic recv_expect(input string tag, input int stall, input logic [7:0] exp);
      logic [7:0] b;
      recv_byte(stall, b);
      check(tag, 32'(b), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr_base;
      int rd_base;
      logic [7:0] frame_w [9];
      logic [7:0] exp_rd  [4];

      reset     = 1'b1;
      rx_data   = '0;
      rx_valid  = 1'b0;
      tx_ready  = 1'b0;
      rdata_val = 32'hDEADBEEF;
      repeat (3) step();

      check("rst_busy",    32'(busy),     32'd0);
      check("rst_txvalid", 32'(tx_valid), 32'd0);
      check("rst_txdata",  32'(tx_data),  32'd0);
      check("rst_wr_rd",   32'({wr, rd}), 32'd0);
      check("rst_addr",    addr,          32'd0);
      check("rst_overrun", 32'(overrun),  32'd0);
      reset = 1'b0;
      step();

      // Write frame: wr pulse one cycle after last byte, then ACK.
      frame_w = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      foreach (frame_w[i]) send_byte(frame_w[i]);
      check("wr_pulse", 32'(wr),   32'd1);
      check("wr_rd_low", 32'(rd),  32'd0);
      check("wr_addr",  addr,      32'h0000_0010);
      check("wr_wdata", wdata,     32'hDEADBEEF);
      step();
      check("wr_single",  32'(wr),       32'd0);
      check("ack_valid",  32'(tx_valid), 32'd1);
      check("ack_data",   32'(tx_data),  32'h4B);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      check("ack_done_valid", 32'(tx_valid), 32'd0);
      check("ack_done_busy",  32'(busy),     32'd0);
      check("wr_count",       32'(wr_cnt),   32'd1);

      // Read frame: one rd pulse, four response bytes MSB first.
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      check("rd_pulse", 32'(rd), 32'd1);
      check("rd_addr",  addr,    32'h0000_0010);
      step();
      check("rd_single", 32'(rd),       32'd0);
      check("rd_txvalid", 32'(tx_valid), 32'd1);
      exp_rd = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      foreach (exp_rd[i]) recv_expect($sformatf("rd_byte%0d", i), 0, exp_rd[i]);
      check("rd_done_busy", 32'(busy),   32'd0);
      check("rd_count",     32'(rd_cnt), 32'd1);

      // Read with the transmitter stalling 5 cycles per byte.
      rdata_val = 32'h1234_5678;
      rd_base   = rd_cnt;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
      exp_rd = '{8'h12, 8'h34, 8'h56, 8'h78};
      foreach (exp_rd[i]) recv_expect($sformatf("stall_byte%0d", i), 5, exp_rd[i]);
      check("stall_rd_count", 32'(rd_cnt - rd_base), 32'd1);
      check("stall_rd_addr",  rd_addr,               32'h0000_0020);
      check("stall_busy",     32'(busy),             32'd0);

      // Junk bytes, a lone write command, then silence until timeout.
      wr_base = wr_cnt;
      rd_base = rd_cnt;
      send_byte(8'h00);
      check("junk_idle", 32'(busy), 32'd0);
      send_byte(8'h41);
      send_byte(8'h57);
      check("tmo_start_busy", 32'(busy), 32'd1);
      repeat (TMO - 1) step();
      check("tmo_edge_busy", 32'(busy), 32'd1);
      step();
      check("tmo_dropped", 32'(busy), 32'd0);
      check("tmo_no_access", 32'((wr_cnt - wr_base) + (rd_cnt - rd_base)), 32'd0);
      check("tmo_no_tx", 32'(tx_valid), 32'd0);

      // Write with maximal surviving gaps and an unaligned address.
      frame_w = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
      foreach (frame_w[i]) send_byte(frame_w[i], (i == 0) ? 0 : TMO - 1);
      check("gap_wr_pulse", 32'(wr), 32'd1);
      check("align_addr",   addr,    32'h0000_0010);
      check("gap_wdata",    wdata,   32'h0BADF00D);
      recv_expect("gap_ack", 0, 8'h4B);
      check("pre_overrun", 32'(overrun), 32'd0);

      // Byte arriving during the response sets overrun and is dropped.
      rdata_val = 32'hCAFE_0042;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
      step();
      send_byte(8'h57);
      check("overrun_set", 32'(overrun), 32'd1);
      exp_rd = '{8'hCA, 8'hFE, 8'h00, 8'h42};
      foreach (exp_rd[i]) recv_expect($sformatf("ovr_byte%0d", i), 0, exp_rd[i]);
      step();
      check("ovr_byte_dropped", 32'(busy),    32'd0);
      check("overrun_sticky",   32'(overrun), 32'd1);

      // Reset in the middle of the address phase.
      wr_base = wr_cnt;
      rd_base = rd_cnt;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      reset = 1'b1;
      #1;
      check("mid_rst_busy",    32'(busy),     32'd0);
      check("mid_rst_overrun", 32'(overrun),  32'd0);
      check("mid_rst_txvalid", 32'(tx_valid), 32'd0);
      check("mid_rst_txdata",  32'(tx_data),  32'd0);
      check("mid_rst_bus",     32'({wr, rd}) | addr | wdata, 32'd0);
      step();
      reset = 1'b0;
      frame_w = '{8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00};
      foreach (frame_w[i]) send_byte(frame_w[i]);
      repeat (5) step();
      check("post_rst_no_access", 32'((wr_cnt - wr_base) + (rd_cnt - rd_base)), 32'd0);
      check("post_rst_idle", 32'(busy), 32'd0);
      check("never_wr_and_rd", 32'(both_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
